// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared mode encodings and default LFSR constants
//
// Purpose: mode encoding for lfsr_gen and default Fibonacci taps, Galois
// polynomials and seeds for common register widths. Tap masks use the
// shift-left form, where bit i set XORs state[i] into the new bit 0.
// Galois polynomials list only the low terms; x^WIDTH is implied.
// Each width uses the same primitive polynomial in both modes, so both
// modes produce maximal-length sequences.
package lfsr_pkg;

  typedef enum logic {
    MODE_FIB = 1'b0,
    MODE_GAL = 1'b1
  } lfsr_mode_e;

  // x^5 + x^3 + 1
  localparam logic [4:0]  LFSR5_FIB_TAPS  = 5'b10100;
  localparam logic [4:0]  LFSR5_GAL_POLY  = 5'b01001;
  localparam logic [4:0]  LFSR5_SEED      = 5'b00001;

  // x^8 + x^6 + x^5 + x^4 + 1
  localparam logic [7:0]  LFSR8_FIB_TAPS  = 8'b1011_1000;
  localparam logic [7:0]  LFSR8_GAL_POLY  = 8'b0111_0001;
  localparam logic [7:0]  LFSR8_SEED      = 8'h01;

  // x^16 + x^15 + x^13 + x^4 + 1
  localparam logic [15:0] LFSR16_FIB_TAPS = 16'hD008;
  localparam logic [15:0] LFSR16_GAL_POLY = 16'hA011;
  localparam logic [15:0] LFSR16_SEED     = 16'h0001;

  // x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR32_FIB_TAPS = 32'h8020_0003;
  localparam logic [31:0] LFSR32_GAL_POLY = 32'h0040_0007;
  localparam logic [31:0] LFSR32_SEED     = 32'h0000_0001;

endpackage

// File: rtl/lfsr_next_state.sv
// rtl/lfsr_next_state.sv - combinational LFSR next-state function
//
// Purpose: computes one LFSR step in either Fibonacci or Galois form.
// Ports:
//   state  in   WIDTH  current register state
//   mode   in   1      MODE_FIB or MODE_GAL
//   next   out  WIDTH  state after one step
module lfsr_next_state
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH    = 5,
  parameter logic [WIDTH-1:0] FIB_TAPS = LFSR5_FIB_TAPS,
  parameter logic [WIDTH-1:0] GAL_POLY = LFSR5_GAL_POLY
) (
  input  logic [WIDTH-1:0] state,
  input  lfsr_mode_e       mode,
  output logic [WIDTH-1:0] next
);

  logic [WIDTH-1:0] fib_next;
  logic [WIDTH-1:0] gal_next;

  // Fibonacci: parity of the tapped bits shifts in at the bottom.
  assign fib_next = {state[WIDTH-2:0], ^(state & FIB_TAPS)};

  // Galois: the bit shifted out of the top folds back through the polynomial.
  assign gal_next = {state[WIDTH-2:0], 1'b0} ^ (state[WIDTH-1] ? GAL_POLY : '0);

  assign next = (mode == MODE_GAL) ? gal_next : fib_next;

endmodule

// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - Fibonacci/Galois LFSR with period measurement
//
// Purpose: WIDTH-bit LFSR that steps on en, reloads on load, and measures
// the number of steps taken to return to the reference seed.
// Ports:
//   clk      in   1      clock, rising edge
//   rst      in   1      synchronous active-high reset
//   en       in   1      advance one step
//   load     in   1      load seed_in (wins over en)
//   seed_in  in   WIDTH  seed for load; zero is replaced by SEED
//   mode     in   1      0 = Fibonacci, 1 = Galois
//   out      out  WIDTH  current state
//   bit_out  out  1      serial output, out[WIDTH-1]
//   wrap     out  1      pulse: state has returned to the reference seed
//   lockup   out  1      pulse: an all-zero seed was rejected
//   period   out  WIDTH  step count of the last completed cycle
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH    = 5,
  parameter logic [WIDTH-1:0] FIB_TAPS = LFSR5_FIB_TAPS,
  parameter logic [WIDTH-1:0] GAL_POLY = LFSR5_GAL_POLY,
  parameter logic [WIDTH-1:0] SEED     = LFSR5_SEED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             mode,
  output logic [WIDTH-1:0] out,
  output logic             bit_out,
  output logic             wrap,
  output logic             lockup,
  output logic [WIDTH-1:0] period
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] state_q,  state_d;
  logic [WIDTH-1:0] ref_q,    ref_d;
  logic [WIDTH-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             wrap_q,   wrap_d;
  logic             lockup_q, lockup_d;

  logic [WIDTH-1:0] raw_next;
  logic [WIDTH-1:0] step_next;

  lfsr_next_state #(
    .WIDTH    (WIDTH),
    .FIB_TAPS (FIB_TAPS),
    .GAL_POLY (GAL_POLY)
  ) u_next (
    .state (state_q),
    .mode  (lfsr_mode_e'(mode)),
    .next  (raw_next)
  );

  // With a badly chosen tap mask a nonzero state could step to zero and
  // stall forever; fall back to SEED so the all-zero state stays unreachable.
  assign step_next = (raw_next == '0) ? SEED : raw_next;

  always_comb begin
    state_d  = state_q;
    ref_d    = ref_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    wrap_d   = 1'b0;
    lockup_d = 1'b0;
    if (load) begin
      cnt_d = '0;
      if (seed_in != '0) begin
        state_d = seed_in;
        ref_d   = seed_in;
      end else begin
        state_d  = SEED;
        ref_d    = SEED;
        lockup_d = 1'b1;
      end
    end else if (en) begin
      state_d = step_next;
      if (step_next == ref_q) begin
        // Returning to the reference seed closes a cycle; this step counts.
        wrap_d   = 1'b1;
        period_d = cnt_q + ONE;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SEED;
      ref_q    <= SEED;
      cnt_q    <= '0;
      period_q <= '0;
      wrap_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ref_q    <= ref_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      wrap_q   <= wrap_d;
      lockup_q <= lockup_d;
    end
  end

  assign out     = state_q;
  assign bit_out = state_q[WIDTH-1];
  assign wrap    = wrap_q;
  assign lockup  = lockup_q;
  assign period  = period_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// tb/tb_lfsr_gen.sv - directed self-checking bench for lfsr_gen
module tb_lfsr_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       load;
  logic [4:0] seed_in;
  logic       mode;
  logic [4:0] out;
  logic       bit_out;
  logic       wrap;
  logic       lockup;
  logic [4:0] period;

  int n_checks = 0;
  int n_pass   = 0;

  lfsr_gen dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .load    (load),
    .seed_in (seed_in),
    .mode    (mode),
    .out     (out),
    .bit_out (bit_out),
    .wrap    (wrap),
    .lockup  (lockup),
    .period  (period)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; load = 1'b0; seed_in = 5'd0;
    tick();
    rst = 1'b0;
  endtask

  // From reset, 31 steps must visit distinct states and wrap only on the last.
  task automatic run_period(input logic m);
    bit seen [0:31];
    for (int i = 0; i < 32; i++) seen[i] = 1'b0;
    seen[1] = 1'b1;
    mode = m; en = 1'b1;
    for (int i = 1; i <= 31; i++) begin
      tick();
      if (i < 31) begin
        check("period_nowrap", 32'(wrap), 32'd0);
        check("period_unique", 32'(seen[out]), 32'd0);
        seen[out] = 1'b1;
      end else begin
        check("period_wrap", 32'(wrap), 32'd1);
        check("period_out", 32'(out), 32'd1);
        check("period_val", 32'(period), 32'd31);
      end
    end
    en = 1'b0;
    tick();
    check("wrap_oneshot", 32'(wrap), 32'd0);
    check("period_hold", 32'(period), 32'd31);
  endtask

  logic [4:0] fib_seq [0:9];
  logic [4:0] gal_seq [0:4];
  bit         found;

  initial begin
    fib_seq = '{5'b00010, 5'b00100, 5'b01001, 5'b10010, 5'b00101,
                5'b01011, 5'b10110, 5'b01100, 5'b11001, 5'b10011};
    gal_seq = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b01001};
    mode = 1'b0;

    // Reset state and hold
    do_reset();
    check("rst_out", 32'(out), 32'd1);
    check("rst_period", 32'(period), 32'd0);
    check("rst_wrap", 32'(wrap), 32'd0);
    check("rst_lockup", 32'(lockup), 32'd0);
    check("rst_bit_out", 32'(bit_out), 32'd0);
    tick();
    check("hold_out", 32'(out), 32'd1);

    // Fibonacci sequence
    mode = 1'b0; en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("fib_seq", 32'(out), 32'(fib_seq[i]));
      check("fib_bit_out", 32'(bit_out), 32'(fib_seq[i][4]));
    end

    // Galois sequence
    do_reset();
    mode = 1'b1; en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("gal_seq", 32'(out), 32'(gal_seq[i]));
    end

    // Full periods in both modes
    do_reset();
    run_period(1'b0);
    do_reset();
    run_period(1'b1);

    // Zero seed load: substitute SEED, lockup pulse, period held
    mode = 1'b0; en = 1'b1;
    tick(); tick();
    en = 1'b0; load = 1'b1; seed_in = 5'b00000;
    tick();
    load = 1'b0;
    check("lock_out", 32'(out), 32'd1);
    check("lock_pulse", 32'(lockup), 32'd1);
    check("lock_period", 32'(period), 32'd31);
    tick();
    check("lock_oneshot", 32'(lockup), 32'd0);

    // Load wins over en; new reference seed gives a 31-step cycle
    load = 1'b1; en = 1'b1; seed_in = 5'b10110;
    tick();
    load = 1'b0;
    check("load_out", 32'(out), 32'b10110);
    check("load_lockup", 32'(lockup), 32'd0);
    check("load_period", 32'(period), 32'd31);
    tick();
    check("load_step", 32'(out), 32'b01100);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (wrap) found = 1'b1;
    end
    check("seed_wrap_seen", 32'(found), 32'd1);
    check("seed_wrap_out", 32'(out), 32'b10110);
    check("seed_wrap_period", 32'(period), 32'd31);

    // Mode change mid-sequence from 01100
    en = 1'b1; mode = 1'b0;
    tick();
    check("mix_fib", 32'(out), 32'b01100);
    mode = 1'b1;
    tick();
    check("mix_gal1", 32'(out), 32'b11000);
    tick();
    check("mix_gal2", 32'(out), 32'b11001);

    // Reset mid-sequence after 10 steps, with load and en also high
    do_reset();
    mode = 1'b0; en = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("ten_steps", 32'(out), 32'b10011);
    rst = 1'b1; load = 1'b1; seed_in = 5'b10110; en = 1'b1;
    tick();
    check("midrst_out", 32'(out), 32'd1);
    check("midrst_period", 32'(period), 32'd0);
    check("midrst_wrap", 32'(wrap), 32'd0);
    check("midrst_lockup", 32'(lockup), 32'd0);
    rst = 1'b0; load = 1'b0;
    tick();
    check("post_rst_step", 32'(out), 32'b00010);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
